// File: rtl/clk_sw_pkg.sv
// clk_sw_pkg: constants shared by the clock-switch controller, the clock
// selection mux and the host format decoder.
//   - format code localparams (PCM rate/width grid, DSD, STOP)
//   - controller state encoding
//   - fmt_supported(): 1 when a code names a clock the mux can produce
package clk_sw_pkg;

  // Upper nibble selects sample width (0=16b, 2=24b, 4=32b),
  // lower nibble selects rate (0=44.1k 1=48k 2=88.2k 3=96k 4=176.4k 5=192k).
  localparam logic [7:0] FMT_44K16  = 8'h00;
  localparam logic [7:0] FMT_44K24  = 8'h20;
  localparam logic [7:0] FMT_44K32  = 8'h40;
  localparam logic [7:0] FMT_48K16  = 8'h01;
  localparam logic [7:0] FMT_48K24  = 8'h21;
  localparam logic [7:0] FMT_48K32  = 8'h41;
  localparam logic [7:0] FMT_88K16  = 8'h02;
  localparam logic [7:0] FMT_88K24  = 8'h22;
  localparam logic [7:0] FMT_88K32  = 8'h42;
  localparam logic [7:0] FMT_96K16  = 8'h03;
  localparam logic [7:0] FMT_96K24  = 8'h23;
  localparam logic [7:0] FMT_96K32  = 8'h43;
  localparam logic [7:0] FMT_176K16 = 8'h04;
  localparam logic [7:0] FMT_176K24 = 8'h24;
  localparam logic [7:0] FMT_176K32 = 8'h44;
  localparam logic [7:0] FMT_192K16 = 8'h05;
  localparam logic [7:0] FMT_192K24 = 8'h25;
  localparam logic [7:0] FMT_192K32 = 8'h45;
  localparam logic [7:0] FMT_DSD    = 8'h80;
  localparam logic [7:0] FMT_STOP   = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUTE,
    ST_WAIT_FRAME,
    ST_GATE,
    ST_SWITCH,
    ST_SETTLE,
    ST_UNMUTE
  } state_e;

  function automatic logic fmt_supported(input logic [7:0] code);
    logic width_ok;
    logic rate_ok;
    width_ok = (code[7:4] == 4'h0) || (code[7:4] == 4'h2) || (code[7:4] == 4'h4);
    rate_ok  = (code[3:0] <= 4'h5);
    return (width_ok && rate_ok) || (code == FMT_DSD) || (code == FMT_STOP);
  endfunction

endpackage

// File: rtl/clock_switch_ctrl_timer.sv
// clk_sw_timer: loadable down-counter shared by every timed state.
//   clk, rst    : system clock, synchronous active-high reset
//   load_i      : load value_i this edge (takes priority over counting)
//   value_i     : load value, i.e. (state length - 1)
//   expired_o   : count has reached zero; the current cycle is the last one
// The counter saturates at zero, so it never wraps.
module clk_sw_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                 cnt_q <= '0;
    else if (load_i)         cnt_q <= value_i;
    else if (cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/clock_switch_ctrl.sv
// clock_switch_ctrl: sequences bit-clock mux changes so they are glitch- and
// click-free: mute -> align to frame -> gate -> select -> settle -> ungate
// -> unmute.
//   clk, rst                 : system clock, synchronous active-high reset
//   fmt_req_valid/code/ready : format request handshake (held off while busy)
//   frame_sync               : 1-cycle LRCK frame boundary pulse (clk domain)
//   sel_code                 : code driven to the clock mux (FF = stopped)
//   clk_gate_en              : 1 = selected bit clock passes
//   mute                     : 1 = datapath muted
//   busy                     : switch sequence in progress
//   switch_done / err_unsupported / err_timeout : 1-cycle status pulses
module clock_switch_ctrl
  import clk_sw_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int MUTE_CYCLES   = 256,
  parameter int FRAME_TIMEOUT = 4096,
  parameter int GATE_CYCLES   = 8,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fmt_req_valid,
  input  logic [7:0] fmt_req_code,
  output logic       fmt_req_ready,
  input  logic       frame_sync,
  output logic [7:0] sel_code,
  output logic       clk_gate_en,
  output logic       mute,
  output logic       busy,
  output logic       switch_done,
  output logic       err_unsupported,
  output logic       err_timeout
);

  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;
  localparam bit PARAMS_OK =
    (MUTE_CYCLES   >= 1) && (longint'(MUTE_CYCLES)   <= CNT_MAX) &&
    (FRAME_TIMEOUT >= 1) && (longint'(FRAME_TIMEOUT) <= CNT_MAX) &&
    (GATE_CYCLES   >= 1) && (longint'(GATE_CYCLES)   <= CNT_MAX) &&
    (SETTLE_CYCLES >= 1) && (longint'(SETTLE_CYCLES) <= CNT_MAX);

  if (!PARAMS_OK) begin : g_param_err
    $error("clock_switch_ctrl: a cycle count is zero or does not fit in CNT_W");
  end

  // Timer holds (length - 1) so a state lasts exactly its nominal length.
  localparam logic [CNT_W-1:0] MUTE_V   = CNT_W'(MUTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FRAME_V  = CNT_W'(FRAME_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GATE_V   = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_V = CNT_W'(SETTLE_CYCLES - 1);

  state_e     state_q;
  logic [7:0] sel_q, req_q;
  logic       gate_q, mute_q, busy_q, done_q, unsup_q, tmo_q;

  logic             accept, running, req_ok, req_same;
  logic             tmr_load, tmr_exp;
  logic [CNT_W-1:0] tmr_val;

  assign fmt_req_ready = (state_q == ST_IDLE) && !rst;
  assign accept        = fmt_req_valid && fmt_req_ready;
  assign running       = (sel_q != FMT_STOP);
  assign req_ok        = fmt_supported(fmt_req_code);
  assign req_same      = (fmt_req_code == sel_q);

  // Timer reload mirrors the FSM transitions below: every entry into a timed
  // state loads that state's length in the same edge.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      ST_IDLE: if (accept && req_ok && !req_same && running) begin
        tmr_load = 1'b1; tmr_val = MUTE_V;
      end
      ST_MUTE: if (tmr_exp) begin
        tmr_load = 1'b1; tmr_val = FRAME_V;
      end
      ST_WAIT_FRAME: if (frame_sync || tmr_exp) begin
        tmr_load = 1'b1; tmr_val = GATE_V;
      end
      ST_SWITCH: if (req_q != FMT_STOP) begin
        tmr_load = 1'b1; tmr_val = SETTLE_V;
      end
      ST_SETTLE: if (tmr_exp) begin
        tmr_load = 1'b1; tmr_val = MUTE_V;
      end
      default: ;
    endcase
  end

  clk_sw_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (tmr_load),
    .value_i  (tmr_val),
    .expired_o(tmr_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= FMT_STOP;
      req_q   <= FMT_STOP;
      gate_q  <= 1'b0;
      mute_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      unsup_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      unsup_q <= 1'b0;
      tmo_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          // busy stays up through the switch_done cycle, drops after it
          busy_q <= 1'b0;
          if (accept) begin
            if (!req_ok) begin
              unsup_q <= 1'b1;
            end else if (req_same) begin
              done_q <= 1'b1;
            end else begin
              req_q  <= fmt_req_code;
              busy_q <= 1'b1;
              if (running) begin
                mute_q  <= 1'b1;
                state_q <= ST_MUTE;
              end else begin
                // stopped: clock already gated and muted, go straight to select
                state_q <= ST_SWITCH;
              end
            end
          end
        end
        ST_MUTE: if (tmr_exp) state_q <= ST_WAIT_FRAME;
        ST_WAIT_FRAME: begin
          // sync on the expiry cycle still counts as aligned
          if (frame_sync || tmr_exp) begin
            gate_q  <= 1'b0;
            tmo_q   <= !frame_sync;
            state_q <= ST_GATE;
          end
        end
        ST_GATE: if (tmr_exp) state_q <= ST_SWITCH;
        ST_SWITCH: begin
          sel_q <= req_q;
          if (req_q == FMT_STOP) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: if (tmr_exp) begin
          gate_q  <= 1'b1;
          state_q <= ST_UNMUTE;
        end
        ST_UNMUTE: if (tmr_exp) begin
          mute_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sel_code        = sel_q;
  assign clk_gate_en     = gate_q;
  assign mute            = mute_q;
  assign busy            = busy_q;
  assign switch_done     = done_q;
  assign err_unsupported = unsup_q;
  assign err_timeout     = tmo_q;

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// Self-checking bench for clock_switch_ctrl. Expected status pulses and
// sel_code changes are queued with their cycle numbers when a request is
// issued; a negedge monitor pops and compares them as the DUT produces them.
module tb_clock_switch_ctrl;

  localparam int MUTE_C = 256, FRAME_TO = 4096, GATE_C = 8, SETTLE_C = 64;
  localparam int EV_DONE = 0, EV_UNSUP = 1, EV_TO = 2, EV_SEL = 3;

  logic       clk = 1'b0, rst = 1'b1, fmt_req_valid = 1'b0, frame_sync = 1'b0;
  logic [7:0] fmt_req_code = 8'h00;
  logic       fmt_req_ready, clk_gate_en, mute, busy, switch_done, err_unsupported, err_timeout;
  logic [7:0] sel_code;

  clock_switch_ctrl #(
    .CNT_W(16), .MUTE_CYCLES(MUTE_C), .FRAME_TIMEOUT(FRAME_TO),
    .GATE_CYCLES(GATE_C), .SETTLE_CYCLES(SETTLE_C)
  ) dut (
    .clk(clk), .rst(rst), .fmt_req_valid(fmt_req_valid), .fmt_req_code(fmt_req_code),
    .fmt_req_ready(fmt_req_ready), .frame_sync(frame_sync), .sel_code(sel_code),
    .clk_gate_en(clk_gate_en), .mute(mute), .busy(busy), .switch_done(switch_done),
    .err_unsupported(err_unsupported), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int kind; int cyc; logic [7:0] val; } ev_t;
  ev_t        exp_q[$];
  int         total = 0, bad = 0;
  bit         mon_en = 1'b0;
  logic [7:0] cur_sel = 8'hFF;

  task automatic push(input int k, input int c, input logic [7:0] v);
    ev_t e;
    e.kind = k; e.cyc = c; e.val = v;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse and every sel_code change must match the queue head.
  initial begin : monitor
    logic [7:0] prev_sel;
    logic       prev_gate;
    int         kd;
    bit         hit;
    ev_t        e;
    prev_sel = 8'hFF; prev_gate = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (sel_code !== prev_sel) begin
          total++;
          if (prev_gate !== 1'b0 || clk_gate_en !== 1'b0) begin
            bad++; $display("FAIL gate_invariant: sel %h->%h at cyc=%0d with gate prev=%b now=%b, required 0", prev_sel, sel_code, cyc, prev_gate, clk_gate_en);
          end
        end
        for (int i = 0; i < 4; i++) begin
          case (i)
            0: begin kd = EV_TO;    hit = (err_timeout === 1'b1); end
            1: begin kd = EV_UNSUP; hit = (err_unsupported === 1'b1); end
            2: begin kd = EV_SEL;   hit = (sel_code !== prev_sel); end
            default: begin kd = EV_DONE; hit = (switch_done === 1'b1); end
          endcase
          if (hit) begin
            total++;
            if (exp_q.size() == 0) begin
              bad++; $display("FAIL event: unexpected kind=%0d at cyc=%0d sel=%h, none required", kd, cyc, sel_code);
            end else begin
              e = exp_q.pop_front();
              if (e.kind != kd || e.cyc != cyc || (kd == EV_SEL && e.val !== sel_code)) begin
                bad++; $display("FAIL event: got kind=%0d cyc=%0d val=%h, required kind=%0d cyc=%0d val=%h", kd, cyc, sel_code, e.kind, e.cyc, e.val);
              end
            end
          end
        end
      end
      prev_sel = sel_code; prev_gate = clk_gate_en;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // All tasks run in the phase #1 after a rising edge; cyc is the current cycle.
  task automatic wait_to(input int t);
    if (cyc > t) begin total++; bad++; $display("FAIL wait_to: now=%0d past target=%0d", cyc, t); end
    while (cyc < t) begin @(posedge clk); #1; end
  endtask

  // Drive a request until accepted; a = first cycle after the accepting edge.
  task automatic send(input logic [7:0] code, output int a);
    int n;
    n = 0;
    fmt_req_valid = 1'b1; fmt_req_code = code;
    while (fmt_req_ready !== 1'b1 && n < 10000) begin @(posedge clk); #1; n++; end
    if (n >= 10000) begin total++; bad++; $display("FAIL send_ready: ready=%b after %0d cycles, required 1", fmt_req_ready, n); end
    @(posedge clk); #1;
    a = cyc;
    fmt_req_valid = 1'b0;
  endtask

  task automatic do_direct_switch(input logic [7:0] code);
    int a;
    send(code, a);
    push(EV_SEL, a + 1, code);
    push(EV_DONE, a + 1 + SETTLE_C + MUTE_C, 8'h00);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL direct_busy: got %b required 1", busy); end
    total++; if (fmt_req_ready !== 1'b0) begin bad++; $display("FAIL direct_ready: got %b required 0", fmt_req_ready); end
    total++; if (sel_code !== cur_sel) begin bad++; $display("FAIL direct_sel_hold: got %h required %h", sel_code, cur_sel); end
    wait_to(a + 1);
    total++; if (sel_code !== code || clk_gate_en !== 1'b0) begin bad++; $display("FAIL direct_sel: got sel=%h gate=%b required sel=%h gate=0", sel_code, clk_gate_en, code); end
    wait_to(a + SETTLE_C);
    total++; if (clk_gate_en !== 1'b0) begin bad++; $display("FAIL direct_settle_gate: got %b required 0", clk_gate_en); end
    wait_to(a + SETTLE_C + 1);
    total++; if (clk_gate_en !== 1'b1 || mute !== 1'b1) begin bad++; $display("FAIL direct_ungate: got gate=%b mute=%b required 1,1", clk_gate_en, mute); end
    wait_to(a + SETTLE_C + MUTE_C);
    total++; if (mute !== 1'b1) begin bad++; $display("FAIL direct_unmute_early: got %b required 1", mute); end
    wait_to(a + SETTLE_C + MUTE_C + 1);
    total++; if (mute !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL direct_done: got mute=%b busy=%b required 0,1", mute, busy); end
    wait_to(a + SETTLE_C + MUTE_C + 2);
    total++; if (busy !== 1'b0 || fmt_req_ready !== 1'b1) begin bad++; $display("FAIL direct_idle: got busy=%b ready=%b required 0,1", busy, fmt_req_ready); end
    cur_sel = code;
  endtask

  // k >= 0: frame_sync k cycles into WAIT_FRAME; k < 0: no sync (timeout).
  // early: also pulse frame_sync during MUTE, which must be ignored.
  task automatic do_running_switch(input logic [7:0] code, input int k, input bit early);
    int a, w, g, s;
    send(code, a);
    w = a + MUTE_C;
    g = (k >= 0) ? w + k + 1 : w + FRAME_TO;   // first GATE cycle
    s = g + GATE_C + 1;                        // first cycle with new sel
    if (k < 0) push(EV_TO, g, 8'h00);
    push(EV_SEL, s, code);
    push(EV_DONE, (code == 8'hFF) ? s : s + SETTLE_C + MUTE_C, 8'h00);
    total++; if (mute !== 1'b1 || busy !== 1'b1 || clk_gate_en !== 1'b1) begin bad++; $display("FAIL run_accept: got mute=%b busy=%b gate=%b required 1,1,1", mute, busy, clk_gate_en); end
    if (early) begin
      wait_to(a + 50); frame_sync = 1'b1;
      wait_to(a + 51); frame_sync = 1'b0;
    end
    wait_to(w - 1);
    total++; if (clk_gate_en !== 1'b1 || mute !== 1'b1 || sel_code !== cur_sel) begin bad++; $display("FAIL run_mute: got gate=%b mute=%b sel=%h required 1,1,%h", clk_gate_en, mute, sel_code, cur_sel); end
    if (k >= 0) begin
      wait_to(w + k); frame_sync = 1'b1;
      wait_to(w + k + 1); frame_sync = 1'b0;
    end else begin
      wait_to(g - 1);
      total++; if (clk_gate_en !== 1'b1 || err_timeout !== 1'b0) begin bad++; $display("FAIL run_wait: got gate=%b tmo=%b required 1,0", clk_gate_en, err_timeout); end
    end
    wait_to(g);
    total++; if (clk_gate_en !== 1'b0 || mute !== 1'b1) begin bad++; $display("FAIL run_gate: got gate=%b mute=%b required 0,1", clk_gate_en, mute); end
    total++; if (err_timeout !== (k < 0)) begin bad++; $display("FAIL run_timeout_flag: got %b required %b", err_timeout, (k < 0)); end
    wait_to(s - 1);
    total++; if (sel_code !== cur_sel || clk_gate_en !== 1'b0) begin bad++; $display("FAIL run_presel: got sel=%h gate=%b required %h,0", sel_code, clk_gate_en, cur_sel); end
    wait_to(s);
    total++; if (sel_code !== code || clk_gate_en !== 1'b0 || mute !== 1'b1) begin bad++; $display("FAIL run_sel: got sel=%h gate=%b mute=%b required %h,0,1", sel_code, clk_gate_en, mute, code); end
    if (code == 8'hFF) begin
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL stop_busy: got %b required 1", busy); end
      wait_to(s + 1);
      total++; if (busy !== 1'b0 || clk_gate_en !== 1'b0 || mute !== 1'b1) begin bad++; $display("FAIL stop_idle: got busy=%b gate=%b mute=%b required 0,0,1", busy, clk_gate_en, mute); end
    end else begin
      wait_to(s + SETTLE_C - 1);
      total++; if (clk_gate_en !== 1'b0) begin bad++; $display("FAIL run_settle: got gate=%b required 0", clk_gate_en); end
      wait_to(s + SETTLE_C);
      total++; if (clk_gate_en !== 1'b1 || mute !== 1'b1) begin bad++; $display("FAIL run_ungate: got gate=%b mute=%b required 1,1", clk_gate_en, mute); end
      wait_to(s + SETTLE_C + MUTE_C);
      total++; if (mute !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL run_done: got mute=%b busy=%b required 0,1", mute, busy); end
      wait_to(s + SETTLE_C + MUTE_C + 1);
      total++; if (busy !== 1'b0 || fmt_req_ready !== 1'b1) begin bad++; $display("FAIL run_idle: got busy=%b ready=%b required 0,1", busy, fmt_req_ready); end
    end
    cur_sel = code;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (sel_code !== 8'hFF || clk_gate_en !== 1'b0 || mute !== 1'b1) begin bad++; $display("FAIL reset_out: got sel=%h gate=%b mute=%b required FF,0,1", sel_code, clk_gate_en, mute); end
    total++; if (busy !== 1'b0 || fmt_req_ready !== 1'b0) begin bad++; $display("FAIL reset_busy_ready: got busy=%b ready=%b required 0,0", busy, fmt_req_ready); end
    total++; if ({switch_done, err_unsupported, err_timeout} !== 3'b000) begin bad++; $display("FAIL reset_pulses: got %b required 000", {switch_done, err_unsupported, err_timeout}); end
    rst = 1'b0;
    #1;
    total++; if (fmt_req_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b required 1", fmt_req_ready); end
    mon_en = 1'b1;
  endtask

  task automatic test_start;          do_direct_switch(8'h01);        endtask
  task automatic test_sync;           do_running_switch(8'h45, 100, 1'b1); endtask
  task automatic test_timeout;        do_running_switch(8'h22, -1, 1'b0);  endtask

  task automatic test_unsupported;
    int a;
    send(8'h07, a);
    push(EV_UNSUP, a, 8'h00);
    total++; if (sel_code !== cur_sel || clk_gate_en !== 1'b1 || mute !== 1'b0) begin bad++; $display("FAIL unsup_hold: got sel=%h gate=%b mute=%b required %h,1,0", sel_code, clk_gate_en, mute, cur_sel); end
    total++; if (fmt_req_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL unsup_ready: got ready=%b busy=%b required 1,0", fmt_req_ready, busy); end
    wait_to(a + 1);
    total++; if (err_unsupported !== 1'b0) begin bad++; $display("FAIL unsup_width: got %b required 0", err_unsupported); end
  endtask

  task automatic test_same_code;
    int a;
    send(cur_sel, a);
    push(EV_DONE, a, 8'h00);
    total++; if (sel_code !== cur_sel || clk_gate_en !== 1'b1 || mute !== 1'b0 || fmt_req_ready !== 1'b1) begin bad++; $display("FAIL same_hold: got sel=%h gate=%b mute=%b ready=%b required %h,1,0,1", sel_code, clk_gate_en, mute, fmt_req_ready, cur_sel); end
  endtask

  // Sync landing exactly on the timeout cycle is not an error; then stop.
  task automatic test_stop;
    do_running_switch(8'h80, FRAME_TO - 1, 1'b0);
    do_running_switch(8'hFF, 3, 1'b0);
  endtask

  task automatic test_reset_mid;
    int a, a2;
    send(8'h24, a);
    push(EV_SEL, a + 1, 8'h24);
    push(EV_SEL, a + 11, 8'hFF);
    a2 = a + 14;
    push(EV_SEL, a2 + 1, 8'h03);
    push(EV_DONE, a2 + 1 + SETTLE_C + MUTE_C, 8'h00);
    wait_to(a + 2);
    fmt_req_valid = 1'b1; fmt_req_code = 8'h03;
    wait_to(a + 5);
    total++; if (fmt_req_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL held_req: got ready=%b busy=%b required 0,1", fmt_req_ready, busy); end
    wait_to(a + 10); rst = 1'b1;
    wait_to(a + 11);
    total++; if (sel_code !== 8'hFF || clk_gate_en !== 1'b0 || mute !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL midrst_out: got sel=%h gate=%b mute=%b busy=%b required FF,0,1,0", sel_code, clk_gate_en, mute, busy); end
    total++; if (fmt_req_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready: got %b required 0", fmt_req_ready); end
    wait_to(a + 13); rst = 1'b0;
    #1;
    total++; if (fmt_req_ready !== 1'b1) begin bad++; $display("FAIL midrst_release: got %b required 1", fmt_req_ready); end
    wait_to(a2);
    fmt_req_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL held_accept: got busy=%b required 1", busy); end
    wait_to(a2 + 1);
    total++; if (sel_code !== 8'h03) begin bad++; $display("FAIL held_sel: got %h required 03", sel_code); end
    wait_to(a2 + 1 + SETTLE_C + MUTE_C + 1);
    total++; if (busy !== 1'b0 || mute !== 1'b0 || clk_gate_en !== 1'b1) begin bad++; $display("FAIL held_final: got busy=%b mute=%b gate=%b required 0,0,1", busy, mute, clk_gate_en); end
    cur_sel = 8'h03;
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset;
    test_start;
    test_sync;
    test_timeout;
    test_unsupported;
    test_same_code;
    test_stop;
    test_reset_mid;
    wait_to(cyc + 4);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL leftover_events: got %0d pending, required 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_switch_ctrl.md
Name: clock_switch_ctrl

Overview:
- Sequencer that drives the bit-clock selection mux on audio format changes, so switches are glitch-free and click-free.
- Sequence: accept format request → mute → align to frame boundary → gate clock off → change select → settle → ungate → unmute.
- Sits between the host/USB format decoder and the clock selection mux; runs on the free-running system clock.

Parameters:
- CNT_W, 16, width of the shared wait counter
- MUTE_CYCLES, 256, cycles held in mute ramp before gating and after ungating (≥1)
- FRAME_TIMEOUT, 4096, max cycles waiting for frame_sync before forcing the switch (≥1)
- GATE_CYCLES, 8, cycles with clock gated before select changes (≥1)
- SETTLE_CYCLES, 64, cycles after select change before ungating (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- fmt_req_valid  in  1  new format code request
- fmt_req_code  in  8  requested format code
- fmt_req_ready  out  1  controller idle, can accept request
- frame_sync  in  1  one-cycle pulse at LRCK frame boundary, already synchronised to clk
- sel_code  out  8  format code driven to clock mux
- clk_gate_en  out  1  1 = selected bit clock passes to output
- mute  out  1  1 = DAC/datapath muted
- busy  out  1  switch sequence in progress
- switch_done  out  1  one-cycle pulse, request completed
- err_unsupported  out  1  one-cycle pulse, request rejected
- err_timeout  out  1  one-cycle pulse, frame_sync wait timed out

Behaviour:
- Reset: rst is synchronous, active-high. While asserted: state IDLE, sel_code=8'hFF (stopped), clk_gate_en=0, mute=1, busy=0, all pulses 0, fmt_req_ready=0. Reset mid-sequence aborts immediately to these values.
- fmt_req_ready is 1 only in IDLE and rst=0. A request is accepted on a clock edge with valid & ready. Requests while busy are held off, not dropped.
- running = (sel_code != 8'hFF).
- Supported codes:
  - 00,20,40,04,24,44,01,21,41,02,22,42,03,23,43,05,25,45 (PCM)
  - 80 (DSD)
  - FF (stop)
- Unsupported accepted code: err_unsupported pulses the next cycle; no other output changes; stays IDLE.
- Accepted code equal to the current sel_code: switch_done pulses the next cycle; no sequence runs.
- State sequence:
  - IDLE → MUTE if running, otherwise directly → SWITCH. busy=1 from the cycle after accept until the cycle switch_done pulses, inclusive.
  - MUTE: mute=1, held exactly MUTE_CYCLES cycles → WAIT_FRAME.
  - WAIT_FRAME: leave on the first frame_sync, or after FRAME_TIMEOUT cycles. On timeout, err_timeout pulses on the exit cycle. → GATE.
  - GATE: clk_gate_en=0, held exactly GATE_CYCLES cycles → SWITCH.
  - SWITCH: one cycle; sel_code ← requested code at the end of this cycle.
    - If the code is FF: switch_done pulses the next cycle; → IDLE with gate=0, mute=1.
    - Otherwise → SETTLE.
  - SETTLE: gate still 0, held SETTLE_CYCLES cycles; clk_gate_en ← 1 on exit → UNMUTE.
  - UNMUTE: mute still 1, held MUTE_CYCLES cycles; on exit mute ← 0, switch_done pulses → IDLE.
- sel_code changes only in SWITCH, and only while clk_gate_en=0. This is an invariant.
- frame_sync in any state other than WAIT_FRAME is ignored. A frame_sync coincident with the timeout expiry counts as sync: no error.
- A single down-counter is loaded on each state entry. It never wraps: CNT_W must hold every parameter, checked at elaboration.

Decomposition:
- Shared package clk_sw_pkg holds:
  - format code localparams (FMT_44K16=8'h00 … FMT_DSD=8'h80, FMT_STOP=8'hFF)
  - state encoding
  - function fmt_supported(code)
  - These constants are shared with the clock mux and the host decoder.
- Sub-module clk_sw_timer: loadable down-counter (load, value, expired) instantiated once.

Test Plan:
- Reset, then request 8'h01 while stopped → SWITCH directly; sel_code=01 one cycle after SWITCH; gate=1 after 64 cycles; mute=0 and switch_done 256 cycles later.
- Running at 01, request 8'h45, frame_sync 100 cycles into WAIT_FRAME:
  - mute stays 1 throughout
  - gate=0 for 8 cycles before sel_code=45
  - no err_timeout
  - done after 64+256 more cycles
- Running, request 8'h22, no frame_sync → err_timeout pulse exactly 4096 cycles into WAIT_FRAME; switch completes normally.
- Request 8'h07 → err_unsupported pulse; sel_code, gate and mute unchanged; ready returns to 1.
- Request 8'hFF while running at 80 → sequence ends with sel_code=FF, gate=0, mute=1; switch_done pulse.
- rst asserted mid-SETTLE → next cycle sel_code=FF, gate=0, mute=1, busy=0. A request held valid during busy is accepted only after IDLE is reached.
